// File: rtl/led_share_ctrl.sv
// Round-robin owner of the three board LEDs: a granted requester drives a PWM-dimmed
// pattern, and with no owner the orange LED shows a slow idle heartbeat.
module led_share_ctrl #(
  parameter int NREQ       = 3,
  parameter int TICK_DIV   = 12000,
  parameter int HOLD_TICKS = 250,
  parameter int HB_TICKS   = 500
) (
  input  logic                clk_12m,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   pat,
  input  logic [4*NREQ-1:0]   bright,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                LEDr,
  output logic                LEDg,
  output logic                LEDo
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      pwm_q, pwm_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   hb_cnt_q, hb_cnt_d;
  logic            hb_q, hb_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [2:0]      led_q, led_d;

  logic            tick_s;
  logic            found_s;
  logic [IW-1:0]   pick_s;
  logic [IW:0]     cand_s;
  logic [NREQ-1:0] own_oh_s;
  logic [NREQ-1:0] new_oh_s;
  logic            others_s;

  assign tick_s   = (presc_q == PW'(TICK_DIV - 1));
  assign own_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << rr_last_q;
  assign new_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << rr_last_d;
  assign others_s = |(req & ~own_oh_s);

  // Free-running prescaler and PWM phase counter.
  always_comb begin
    presc_d = tick_s ? '0 : presc_q + PW'(1);
    pwm_d   = pwm_q + 4'd1;
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    found_s = 1'b0;
    pick_s  = rr_last_q;
    cand_s  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = {1'b0, rr_last_q} + (IW+1)'(i);
      if (cand_s >= (IW+1)'(NREQ)) begin
        cand_s = cand_s - (IW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IW-1:0]]) begin
        pick_s  = cand_s[IW-1:0];
        found_s = 1'b1;
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Ownership FSM, hold timer and heartbeat (heartbeat only advances in IDLE).
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    hold_d    = hold_q;
    hb_d      = hb_q;
    hb_cnt_d  = hb_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          if (hb_cnt_q == BW'(HB_TICKS - 1)) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
          end else begin
            hb_cnt_d = hb_cnt_q + BW'(1);
          end
        end else begin
          hb_cnt_d = hb_cnt_q;
        end
        if (found_s) begin
          state_d   = ST_OWN;
          rr_last_d = pick_s;
          hold_d    = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (tick_s && (hold_q != HW'(HOLD_TICKS))) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = hold_q;
        end
        // Voluntary release wins over preemption; both take the same path.
        if (!req[rr_last_q]) begin
          state_d = ST_GAP;
        end else if ((hold_q == HW'(HOLD_TICKS)) && others_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_OWN;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the same edge.
  always_comb begin
    gnt_d  = '0;
    busy_d = 1'b0;
    led_d  = 3'b000;
    case (state_d)
      ST_IDLE: begin
        led_d = {hb_d, 2'b00};
      end
      ST_OWN: begin
        gnt_d  = new_oh_s;
        busy_d = 1'b1;
        led_d  = pat[rr_last_d*3 +: 3] & {3{pwm_q < bright[rr_last_d*4 +: 4]}};
      end
      default: begin
        led_d = 3'b000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_12m) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= IW'(NREQ - 1);
      presc_q   <= '0;
      pwm_q     <= 4'd0;
      hold_q    <= '0;
      hb_cnt_q  <= '0;
      hb_q      <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      led_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      hold_q    <= hold_d;
      hb_cnt_q  <= hb_cnt_d;
      hb_q      <= hb_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign LEDr = led_q[0];
  assign LEDg = led_q[1];
  assign LEDo = led_q[2];

endmodule

// File: tb/tb_led_share_ctrl.sv
// Randomized bench for led_share_ctrl against a cycle-level behavioural model.
module tb_led_share_ctrl;

  localparam int NREQ = 3;
  localparam int TDIV = 4;
  localparam int HOLD = 3;
  localparam int HBT  = 2;

  logic              clk_12m = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] pat;
  logic [4*NREQ-1:0] bright;
  logic [NREQ-1:0]   gnt;
  logic              busy, LEDr, LEDg, LEDo;

  led_share_ctrl #(
    .NREQ(NREQ), .TICK_DIV(TDIV), .HOLD_TICKS(HOLD), .HB_TICKS(HBT)
  ) dut (
    .clk_12m(clk_12m), .rst(rst), .req(req), .pat(pat), .bright(bright),
    .gnt(gnt), .busy(busy), .LEDr(LEDr), .LEDg(LEDg), .LEDo(LEDo)
  );

  always #5 clk_12m = ~clk_12m;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset, current owner (-1 = none), gap flag,
  // last winner, ticks held by the owner, ticks spent in idle.
  int m_cyc, m_owner, m_last, m_held, m_idle_ticks;
  bit m_gap;
  logic [NREQ-1:0] e_gnt;
  logic            e_busy;
  logic [2:0]      e_led;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (last + i) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Advance the model over one edge using the inputs currently applied, then compare.
  task automatic step();
    bit tick;
    int pwm;
    int k;
    logic [2:0] p;
    logic [3:0] b;
    if (rst) begin
      m_cyc = 0; m_owner = -1; m_gap = 1'b0; m_last = NREQ - 1;
      m_held = 0; m_idle_ticks = 0;
    end else begin
      tick = ((m_cyc % TDIV) == TDIV - 1);
      pwm  = m_cyc % 16;
      if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_owner < 0) begin
        if (tick) m_idle_ticks++;
        k = rr_pick(m_last, req);
        if (k >= 0) begin
          m_owner = k; m_last = k; m_held = 0;
        end
      end else begin
        if (!req[m_owner] || (m_held >= HOLD && (req & ~(NREQ'(1) << m_owner)) != 0)) begin
          m_owner = -1; m_gap = 1'b1;
        end else if (tick) begin
          m_held++;
        end
      end
      m_cyc++;
    end
    e_gnt  = '0;
    e_busy = 1'b0;
    e_led  = 3'b000;
    if (!rst) begin
      if (m_owner >= 0) begin
        e_gnt  = NREQ'(1) << m_owner;
        e_busy = 1'b1;
        p = pat[3*m_owner +: 3];
        b = bright[4*m_owner +: 4];
        e_led = (pwm < int'(b)) ? p : 3'b000;
      end else if (!m_gap) begin
        e_led = {1'(((m_idle_ticks / HBT) % 2)), 2'b00};
      end
    end
    @(posedge clk_12m);
    #1;
    check_eq("gnt", 32'(gnt), 32'(e_gnt));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("leds", 32'({LEDo, LEDg, LEDr}), 32'(e_led));
    check_eq("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic run(input int n, input logic [NREQ-1:0] r, input bit rnd_pb);
    req = r;
    for (int i = 0; i < n; i++) begin
      if (rnd_pb) begin
        pat    = 9'($urandom);
        bright = 12'($urandom);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; pat = '0; bright = '0;
    step(); step();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_led", 32'({LEDo, LEDg, LEDr}), 32'd0);
    rst = 1'b0;
    run(40, 3'b000, 1'b0);
    pat = 9'b000_000_101; bright = 12'h004;
    run(40, 3'b001, 1'b0);
    run(12, 3'b010, 1'b0);
    run(60, 3'b111, 1'b1);
    run(100, 3'b010, 1'b1);
    run(20, 3'b100, 1'b1);
    check_eq("pre_rst_gnt", 32'(gnt), 32'b100);
    rst = 1'b1;
    step();
    check_eq("mid_rst_gnt", 32'(gnt), 32'd0);
    rst = 1'b0;
    run(3, 3'b111, 1'b1);
    check_eq("first_after_rst", 32'(gnt), 32'b001);
    run(20, 3'b111, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom_range(0, 7));
      rst    = ($urandom_range(0, 299) == 0);
      pat    = 9'($urandom);
      bright = 12'($urandom);
      step();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
